tribonacci_checker: RTL and testbench
=====================================

TRIBONACCI_CHECKER -- requirements
Module: tribonacci_checker

Interface
REQ-001 Parameter: WIDTH, default 32, data and term width.
REQ-002 Parameter: CNT_WIDTH, default 16, width of beat counter and error index.
REQ-003 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 start  input  1  one-cycle pulse; reloads seeds, clears status, enters RUN.
REQ-007 in_valid  input  1  producer has a term on in_data.
REQ-008 in_data  input  WIDTH  received sequence term.
REQ-009 in_ready  output  1  checker accepts a beat this cycle.
REQ-010 match  output  1  registered pulse: last accepted beat equalled the expected term.
REQ-011 error  output  1  sticky: a mismatch has occurred since last start.
REQ-012 count  output  CNT_WIDTH  number of beats that matched since last start.
REQ-013 err_index  output  CNT_WIDTH  0-based index of first mismatching beat.
REQ-014 expected  output  WIDTH  term the next accepted beat is compared against.

Function
REQ-015 Expected sequence SHALL be tribonacci with seeds t0=0, t1=1, t2=1, t(n)=t(n-1)+t(n-2)+t(n-3) modulo 2^WIDTH (carry discarded).
REQ-016 Beat accepted iff in_valid && in_ready on a rising edge; no other condition.
REQ-017 States: IDLE, RUN, FAIL, SAT.
REQ-018 in_ready = 1 in RUN and FAIL, 0 in IDLE and SAT, forced 0 in any cycle where start=1.
REQ-019 IDLE -> RUN on start; RUN -> FAIL on first mismatching beat; RUN -> SAT when count reaches 2^CNT_WIDTH-1; FAIL and SAT -> RUN only on start.
REQ-020 Each accepted beat SHALL advance the internal generator by one term, whether it matched or not.
REQ-021 Matching beat in RUN: count increments, match pulses high for exactly the following cycle.
REQ-022 Mismatching beat in RUN: error set, err_index loaded with current beat index (= count), match stays 0, next cycle state = FAIL.
REQ-023 FAIL: beats accepted and discarded; count, err_index, error frozen; match stays 0.
REQ-024 count SHALL saturate at 2^CNT_WIDTH-1, never wrap.
REQ-025 Status latency: match, error, count, err_index reflect a beat one cycle after acceptance.
REQ-026 expected SHALL be combinationally the current generator output (t0 after start).
REQ-027 start in any state: generator reloads seeds, count=0, error=0, err_index=0, match=0, state=RUN next cycle; concurrent beat is not accepted.

Reset
REQ-028 On rst=0 at rising clk: state=IDLE, generator = (0,1,1), count=0, err_index=0, error=0, match=0; in_ready=0, expected=0.
REQ-029 Reset SHALL take priority over start and any beat in the same cycle; reset mid-stream discards all progress.

Structure
REQ-030 Shared package SHALL hold the state enumeration and seed constants T0=0, T1=1, T2=1.
REQ-031 One sub-module tribonacci_step SHALL hold the three term registers with synchronous load-seed and advance controls, output = oldest term.
REQ-032 FSM, counter and compare logic SHALL reside in tribonacci_checker; no other sub-modules.

Verification
REQ-033 Reset, start, feed 0,1,1,2,4,7,13,24,44,81 back-to-back -> count=10, error=0, ten match pulses, expected=149.
REQ-034 WIDTH=8, start, feed 12 correct terms ending 149,18 -> count=12, error=0 (wrap-around 274 mod 256 = 18).
REQ-035 Start, feed 0,1,1,3 -> error=1 cycle after 4th beat, err_index=3, count=3, state FAIL; further beats accepted, count stays 3.
REQ-036 In RUN assert start with in_valid=1, in_data=0 -> in_ready=0 that cycle, beat not counted, count=0, expected=0 next cycle.
REQ-037 CNT_WIDTH=4, feed 20 correct terms with random in_valid gaps -> count saturates at 15, state SAT, in_ready=0.
REQ-038 Drive rst=0 after 5 correct beats -> all outputs at reset values next cycle, state IDLE, in_ready=0 until start.

Source files
------------

// File: rtl/tribonacci_checker_pkg.sv
// Purpose: shared state encoding and generator seed terms for the tribonacci checker.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package tribonacci_checker_pkg;

  // Checker operating states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2,
    SAT  = 2'd3
  } state_t;

  // Seed terms t0, t1, t2 of the expected sequence.
  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 1;
  localparam int unsigned T2 = 1;

endpackage

// File: rtl/tribonacci_step.sv
// Purpose: three-term tribonacci generator; term is the oldest held term.
// Latency: load or advance takes effect on the next rising clk edge.
// Backpressure: holds its terms whenever advance is low.
module tribonacci_step
  import tribonacci_checker_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] term
);

  logic [WIDTH-1:0] t_a;
  logic [WIDTH-1:0] t_b;
  logic [WIDTH-1:0] t_c;

  // Reload seeds on reset or load, otherwise shift the window by one term per advance.
  always_ff @(posedge clk) begin
    if (!rst || load) begin
      t_a <= WIDTH'(T0);
      t_b <= WIDTH'(T1);
      t_c <= WIDTH'(T2);
    end else if (advance) begin
      t_a <= t_b;
      t_b <= t_c;
      t_c <= t_a + t_b + t_c;  // carry out is dropped: sequence is modulo 2^WIDTH
    end
  end

  assign term = t_a;

endmodule

// File: rtl/tribonacci_checker.sv
// Purpose: compares an incoming stream against the tribonacci sequence and reports status.
// Latency: match/error/count/err_index update one cycle after a beat is accepted.
// Backpressure: in_ready high only in RUN or FAIL, and dropped in any cycle start is high.
module tribonacci_checker
  import tribonacci_checker_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 match,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] err_index,
  output logic [WIDTH-1:0]     expected
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  logic   accept;
  logic   hit;

  // A start cycle never takes a beat, so the generator reload cannot race an advance.
  assign in_ready = ((state == RUN) || (state == FAIL)) && !start;
  assign accept   = in_valid && in_ready;
  assign hit      = (in_data == expected);

  tribonacci_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .advance (accept),
    .term    (expected)
  );

  // State, match counter and first-error capture; only RUN beats affect status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      err_index <= '0;
      error     <= 1'b0;
      match     <= 1'b0;
    end else if (start) begin
      state     <= RUN;
      count     <= '0;
      err_index <= '0;
      error     <= 1'b0;
      match     <= 1'b0;
    end else begin
      match <= 1'b0;
      if (accept && (state == RUN)) begin
        if (hit) begin
          match <= 1'b1;
          if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
          // Leave RUN as the counter lands on its ceiling so it can never wrap.
          if (count >= CNT_MAX - 1'b1) begin
            state <= SAT;
          end
        end else begin
          error     <= 1'b1;
          err_index <= count;
          state     <= FAIL;
        end
      end
    end
  end

endmodule

// File: tb/tb_tribonacci_checker.sv
module tb_tribonacci_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance: default parameters.
  logic        start, in_valid, in_ready, match, error;
  logic [31:0] in_data, expected;
  logic [15:0] count, err_index;

  // 8-bit data instance for modulo wrap.
  logic        s8_start, s8_valid, s8_ready, s8_match, s8_error;
  logic [7:0]  s8_data, s8_expected;
  logic [15:0] s8_count, s8_err_index;

  // 4-bit counter instance for saturation.
  logic        ss_start, ss_valid, ss_ready, ss_match, ss_error;
  logic [31:0] ss_data, ss_expected;
  logic [3:0]  ss_count, ss_err_index;

  tribonacci_checker #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .match(match), .error(error), .count(count),
    .err_index(err_index), .expected(expected)
  );

  tribonacci_checker #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .in_valid(s8_valid), .in_data(s8_data),
    .in_ready(s8_ready), .match(s8_match), .error(s8_error), .count(s8_count),
    .err_index(s8_err_index), .expected(s8_expected)
  );

  tribonacci_checker #(.WIDTH(32), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .start(ss_start), .in_valid(ss_valid), .in_data(ss_data),
    .in_ready(ss_ready), .match(ss_match), .error(ss_error), .count(ss_count),
    .err_index(ss_err_index), .expected(ss_expected)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the main instance, kept as sequence position plus status.
  typedef enum int {M_IDLE, M_RUN, M_FAIL, M_SAT} mmode_t;
  mmode_t m_mode;
  int     m_idx, m_cnt, m_eidx;
  bit     m_err, m_match, m_ready;
  logic   rdy_obs;

  // n-th term of the tribonacci sequence modulo 2^w, by direct iteration.
  function automatic logic [63:0] trib(input int n, input int w);
    logic [63:0] a, b, c, t, mask;
    mask = (64'd1 << w) - 64'd1;
    a = 64'd0; b = 64'd1; c = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = (a + b + c) & mask;
      a = b; b = c; c = t;
    end
    return a & mask;
  endfunction

  // Drive one cycle on the main instance and advance the reference model.
  task automatic main_cycle(input bit st, input bit v, input logic [31:0] d);
    logic [31:0] exp_t;
    start = st; in_valid = v; in_data = d;
    #1;
    m_ready = ((m_mode == M_RUN) || (m_mode == M_FAIL)) && !st;
    rdy_obs = in_ready;
    if (!rst) begin
      m_mode = M_IDLE; m_idx = 0; m_cnt = 0; m_err = 0; m_eidx = 0; m_match = 0;
    end else if (st) begin
      m_mode = M_RUN; m_idx = 0; m_cnt = 0; m_err = 0; m_eidx = 0; m_match = 0;
    end else begin
      m_match = 0;
      if (v && m_ready) begin
        exp_t = 32'(trib(m_idx, 32));
        m_idx++;
        if (m_mode == M_RUN) begin
          if (d == exp_t) begin
            m_cnt++;
            m_match = 1;
            if (m_cnt == 65535) m_mode = M_SAT;
          end else begin
            m_err = 1; m_eidx = m_cnt; m_mode = M_FAIL;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    main_cycle(0, 0, 0);
    main_cycle(0, 1, 0);
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", match); end
    n_tests++; if (err_index !== 16'd0) begin n_fail++; $display("FAIL reset_err_index: got %0d want 0", err_index); end
    n_tests++; if (expected !== 32'd0) begin n_fail++; $display("FAIL reset_expected: got %0d want 0", expected); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_tests++; if (s8_ready !== 1'b0 || s8_count !== 16'd0) begin n_fail++; $display("FAIL reset_dut8: ready %b count %0d want 0 0", s8_ready, s8_count); end
    n_tests++; if (ss_ready !== 1'b0 || ss_count !== 4'd0) begin n_fail++; $display("FAIL reset_dut_sat: ready %b count %0d want 0 0", ss_ready, ss_count); end
    rst = 1'b1;
    main_cycle(0, 1, 0);
    n_tests++; if (rdy_obs !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL idle_no_accept: ready %b count %0d want 0 0", rdy_obs, count); end
  endtask

  task automatic test_sequence();
    int pulses = 0;
    main_cycle(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      main_cycle(0, 1, 32'(trib(i, 32)));
      n_tests++; if (rdy_obs !== 1'b1) begin n_fail++; $display("FAIL seq_ready[%0d]: got %b want 1", i, rdy_obs); end
      if (match === 1'b1) pulses++;
    end
    n_tests++; if (pulses != 10) begin n_fail++; $display("FAIL seq_pulses: got %0d want 10", pulses); end
    n_tests++; if (count !== 16'd10) begin n_fail++; $display("FAIL seq_count: got %0d want 10", count); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL seq_error: got %b want 0", error); end
    n_tests++; if (expected !== 32'd149) begin n_fail++; $display("FAIL seq_expected: got %0d want 149", expected); end
    main_cycle(0, 0, 0);
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL seq_match_one_cycle: got %b want 0", match); end
  endtask

  task automatic test_mismatch();
    logic [31:0] feed [4];
    feed[0] = 32'd0; feed[1] = 32'd1; feed[2] = 32'd1; feed[3] = 32'd3;
    main_cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) main_cycle(0, 1, feed[i]);
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL mis_error: got %b want 1", error); end
    n_tests++; if (err_index !== 16'd3) begin n_fail++; $display("FAIL mis_err_index: got %0d want 3", err_index); end
    n_tests++; if (count !== 16'd3) begin n_fail++; $display("FAIL mis_count: got %0d want 3", count); end
    n_tests++; if (match !== 1'b0) begin n_fail++; $display("FAIL mis_match: got %b want 0", match); end
    for (int i = 4; i < 7; i++) begin
      main_cycle(0, 1, 32'(trib(i, 32)));
      n_tests++; if (rdy_obs !== 1'b1) begin n_fail++; $display("FAIL fail_ready[%0d]: got %b want 1", i, rdy_obs); end
      n_tests++; if (count !== 16'd3 || match !== 1'b0) begin n_fail++; $display("FAIL fail_frozen[%0d]: count %0d match %b want 3 0", i, count, match); end
    end
    n_tests++; if (err_index !== 16'd3 || error !== 1'b1) begin n_fail++; $display("FAIL fail_sticky: idx %0d err %b want 3 1", err_index, error); end
    n_tests++; if (expected !== 32'd24) begin n_fail++; $display("FAIL fail_gen_advance: got %0d want 24", expected); end
  endtask

  task automatic test_start_collision();
    main_cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) main_cycle(0, 1, 32'(trib(i, 32)));
    main_cycle(1, 1, 0);
    n_tests++; if (rdy_obs !== 1'b0) begin n_fail++; $display("FAIL coll_ready: got %b want 0", rdy_obs); end
    n_tests++; if (count !== 16'd0) begin n_fail++; $display("FAIL coll_count: got %0d want 0", count); end
    n_tests++; if (expected !== 32'd0) begin n_fail++; $display("FAIL coll_expected: got %0d want 0", expected); end
    n_tests++; if (match !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL coll_status: match %b err %b want 0 0", match, error); end
    main_cycle(0, 1, 0);
    n_tests++; if (count !== 16'd1 || match !== 1'b1 || expected !== 32'd1) begin
      n_fail++; $display("FAIL coll_first_beat: count %0d match %b exp %0d want 1 1 1", count, match, expected);
    end
  endtask

  task automatic test_reset_mid();
    main_cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) main_cycle(0, 1, 32'(trib(i, 32)));
    n_tests++; if (count !== 16'd5) begin n_fail++; $display("FAIL rmid_pre_count: got %0d want 5", count); end
    rst = 1'b0;
    main_cycle(0, 1, 32'(trib(5, 32)));
    n_tests++; if (count !== 16'd0 || error !== 1'b0 || match !== 1'b0 || err_index !== 16'd0) begin
      n_fail++; $display("FAIL rmid_status: count %0d err %b match %b idx %0d want 0 0 0 0", count, error, match, err_index);
    end
    n_tests++; if (expected !== 32'd0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_gen: exp %0d ready %b want 0 0", expected, in_ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      main_cycle(0, 1, 0);
      n_tests++; if (rdy_obs !== 1'b0 || count !== 16'd0) begin n_fail++; $display("FAIL rmid_idle[%0d]: ready %b count %0d want 0 0", i, rdy_obs, count); end
    end
  endtask

  task automatic test_random();
    bit          st, v;
    logic [31:0] d;
    main_cycle(1, 0, 0);
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 24) == 0) ? 32'($urandom) : 32'(trib(m_idx, 32));
      main_cycle(st, v, d);
      n_tests++; if (rdy_obs !== m_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, rdy_obs, m_ready); end
      n_tests++; if (match !== m_match || error !== m_err) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: match %b err %b want %b %b", c, match, error, m_match, m_err);
      end
      n_tests++; if (count !== 16'(m_cnt) || err_index !== 16'(m_eidx)) begin
        n_fail++; $display("FAIL rnd_counts[%0d]: count %0d idx %0d want %0d %0d", c, count, err_index, m_cnt, m_eidx);
      end
      n_tests++; if (expected !== 32'(trib(m_idx, 32))) begin
        n_fail++; $display("FAIL rnd_expected[%0d]: got %0d want %0d", c, expected, 32'(trib(m_idx, 32)));
      end
    end
    main_cycle(0, 0, 0);
  endtask

  task automatic test_wrap8();
    s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s8_valid = 1'b1;
      s8_data  = 8'(trib(i, 8));
      #1;
      n_tests++; if (s8_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b want 1", i, s8_ready); end
      @(posedge clk); #1;
    end
    s8_valid = 1'b0;
    n_tests++; if (s8_count !== 16'd12) begin n_fail++; $display("FAIL wrap_count: got %0d want 12", s8_count); end
    n_tests++; if (s8_error !== 1'b0 || s8_match !== 1'b1) begin n_fail++; $display("FAIL wrap_status: err %b match %b want 0 1", s8_error, s8_match); end
    n_tests++; if (s8_expected !== 8'd248) begin n_fail++; $display("FAIL wrap_expected: got %0d want 248", s8_expected); end
  endtask

  task automatic test_sat();
    int offered = 0, acc = 0, cyc = 0;
    bit v, want_rdy;
    ss_start = 1'b1;
    @(posedge clk); #1;
    ss_start = 1'b0;
    while (offered < 20 && cyc < 300) begin
      v        = ($urandom_range(0, 2) != 0);
      ss_valid = v;
      ss_data  = 32'(trib(acc, 32));
      #1;
      want_rdy = (acc < 15);
      n_tests++; if (ss_ready !== want_rdy) begin n_fail++; $display("FAIL sat_ready[%0d]: got %b want %b", cyc, ss_ready, want_rdy); end
      if (v) begin
        offered++;
        if (ss_ready === 1'b1) acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ss_valid = 1'b0;
    n_tests++; if (offered != 20) begin n_fail++; $display("FAIL sat_budget: offered %0d want 20", offered); end
    n_tests++; if (ss_count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d want 15", ss_count); end
    n_tests++; if (ss_ready !== 1'b0 || ss_error !== 1'b0) begin n_fail++; $display("FAIL sat_state: ready %b err %b want 0 0", ss_ready, ss_error); end
    n_tests++; if (ss_expected !== 32'(trib(15, 32))) begin n_fail++; $display("FAIL sat_expected: got %0d want %0d", ss_expected, 32'(trib(15, 32))); end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    s8_start = 1'b0; s8_valid = 1'b0; s8_data = '0;
    ss_start = 1'b0; ss_valid = 1'b0; ss_data = '0;
    m_mode = M_IDLE; m_idx = 0; m_cnt = 0; m_eidx = 0; m_err = 0; m_match = 0; m_ready = 0;
    test_reset();
    test_sequence();
    test_mismatch();
    test_start_collision();
    test_reset_mid();
    test_random();
    test_wrap8();
    test_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
